// File: rtl/board_gpio_ctrl.sv
// Board GPIO peripheral: LED bank, debounced active-low buttons, sticky press events, level IRQ.
// Latency: register writes land on the write edge; led and irq follow one cycle later; reads return one cycle after bus_re.
// Backpressure: none; every single-cycle bus strobe is accepted, and bus_rvalid pulses exactly once per read.
//
// Ports:
//   CLOCK_50              system clock
//   KEY                   asynchronous active-low reset
//   bus_we / bus_re       one-cycle write / read strobes
//   bus_addr[4:0]         byte address, word select on [4:2]
//   bus_wdata[31:0]       write data
//   bus_rdata[31:0]       read data, held until the next read
//   bus_rvalid            read-data-valid pulse
//   btn_n[NUM_BTN-1:0]    raw asynchronous buttons, 0 = pressed
//   led[NUM_LED-1:0]      LED drive, 1 = on
//   irq                   level interrupt, |(EDGE & IRQ_EN)
//
// Register map (word offsets): 0x00 LED_REG, 0x04 BTN_STATE, 0x08 BTN_EDGE (W1C), 0x0C IRQ_EN,
// 0x10 BLINK_MASK (only when BOARD_GPIO_BLINK_EN is defined; otherwise unmapped).
// Optional macro: BOARD_GPIO_BLINK_EN adds a blink mask XOR-ed onto the LEDs with a free-running phase.

module board_gpio_ctrl #(
    parameter int NUM_LED         = 18,
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BLINK_DIV       = 12500000
) (
    input  logic               CLOCK_50,
    input  logic               KEY,
    input  logic               bus_we,
    input  logic               bus_re,
    input  logic [4:0]         bus_addr,
    input  logic [31:0]        bus_wdata,
    output logic [31:0]        bus_rdata,
    output logic               bus_rvalid,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic [NUM_LED-1:0] led,
    output logic               irq
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] SEL_LED   = 3'd0;
    localparam logic [2:0] SEL_STATE = 3'd1;
    localparam logic [2:0] SEL_EDGE  = 3'd2;
    localparam logic [2:0] SEL_IRQEN = 3'd3;
    localparam logic [2:0] SEL_BLINK = 3'd4;

    logic [2:0] sel;
    assign sel = bus_addr[4:2];

    // Byte-lane bits and data bits above the register widths carry no meaning here.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus_addr[1:0], bus_wdata};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] stable_q, stable_d;   // debounced pin level, 1 = released
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] btn_edge_q, btn_edge_d;
    logic [NUM_BTN-1:0] irq_en_q, irq_en_d;
    logic [NUM_LED-1:0] led_reg_q, led_reg_d;
    logic [NUM_LED-1:0] led_q, led_d;
    logic               irq_q, irq_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;

    logic [NUM_BTN-1:0] press;                // one-cycle stable 1->0 event
    logic [NUM_BTN-1:0] w1c_mask;
    logic [31:0]        rd_word;

`ifdef BOARD_GPIO_BLINK_EN
    localparam int               BLK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

    logic [NUM_LED-1:0] blink_mask_q, blink_mask_d;
    logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
`endif

    // ------------------------------------------------------------------
    // Button synchroniser and debounce
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d  = btn_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                // The synced level must disagree for DEBOUNCE_CYCLES consecutive
                // samples; any agreement in between drops the count back to 0.
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                    press[i]    = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    always_comb begin
        led_reg_d = led_reg_q;
        irq_en_d  = irq_en_q;
        w1c_mask  = '0;
        if (bus_we) begin
            case (sel)
                SEL_LED:   led_reg_d = bus_wdata[NUM_LED-1:0];
                SEL_EDGE:  w1c_mask  = bus_wdata[NUM_BTN-1:0];
                SEL_IRQEN: irq_en_d  = bus_wdata[NUM_BTN-1:0];
                default:   ;
            endcase
        end
        // A press landing in the same cycle as its clear keeps the bit set.
        btn_edge_d = (btn_edge_q & ~w1c_mask) | press;
        irq_d      = |(btn_edge_q & irq_en_q);
    end

`ifdef BOARD_GPIO_BLINK_EN
    always_comb begin
        blink_mask_d  = blink_mask_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
        if (bus_we && sel == SEL_BLINK) begin
            blink_mask_d = bus_wdata[NUM_LED-1:0];
        end
        if (blink_cnt_q == BLK_MAX) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        led_d = led_reg_q ^ (blink_mask_q & {NUM_LED{blink_phase_q}});
    end
`else
    always_comb begin
        led_d = led_reg_q;
    end
`endif

    // ------------------------------------------------------------------
    // Register reads: current (pre-write) contents, registered
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        case (sel)
            SEL_LED:   rd_word[NUM_LED-1:0] = led_reg_q;
            SEL_STATE: rd_word[NUM_BTN-1:0] = ~stable_q;
            SEL_EDGE:  rd_word[NUM_BTN-1:0] = btn_edge_q;
            SEL_IRQEN: rd_word[NUM_BTN-1:0] = irq_en_q;
`ifdef BOARD_GPIO_BLINK_EN
            SEL_BLINK: rd_word[NUM_LED-1:0] = blink_mask_q;
`endif
            default:   rd_word = '0;
        endcase
        rdata_d  = bus_re ? rd_word : rdata_q;
        rvalid_d = bus_re;
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '1;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            btn_edge_q <= '0;
            irq_en_q   <= '0;
            led_reg_q  <= '0;
            led_q      <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            btn_edge_q <= btn_edge_d;
            irq_en_q   <= irq_en_d;
            led_reg_q  <= led_reg_d;
            led_q      <= led_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

`ifdef BOARD_GPIO_BLINK_EN
    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            blink_mask_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_mask_q  <= blink_mask_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    assign led        = led_q;
    assign irq        = irq_q;
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: doc/board_gpio_ctrl.md
Name: board_gpio_ctrl

Overview:
Memory-mapped board I/O peripheral for the RV32I pipeline core. It is the parametrised successor to the fixed 18-LED / single-KEY board hookup.
- Drives a configurable-width LED bank.
- Samples NUM_BTN active-low push-buttons through synchroniser and debounce logic.
- Latches press events and raises a maskable interrupt.
- Sits on the core's data-bus MMIO decode, alongside data memory.

Parameters:
NUM_LED, 18, LED outputs (1..32)
NUM_BTN, 3, active-low button inputs (1..16)
DEBOUNCE_CYCLES, 50000, stable-sample cycles before a button change is accepted (1 ms at 50 MHz; must be >= 2)
BLINK_DIV, 12500000, half-period of blink phase in clocks (only with BOARD_GPIO_BLINK_EN)

Ports:
CLOCK_50  in  1  system clock
KEY  in  1  asynchronous active-low reset
bus_we  in  1  write strobe, one cycle per access
bus_re  in  1  read strobe, one cycle per access
bus_addr  in  5  byte address; bits [4:2] decoded, [1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, valid when bus_rvalid=1
bus_rvalid  out  1  read-data-valid pulse
btn_n  in  NUM_BTN  raw asynchronous buttons, 0 = pressed
led  out  NUM_LED  LED drive, 1 = on
irq  out  1  level interrupt

Behaviour:
- Clock and reset: single clock CLOCK_50. Reset is asynchronous and active-low on KEY; all flops clear immediately when KEY=0. Reset values:
  - led=0, irq=0, bus_rdata=0, bus_rvalid=0
  - LED_REG=0, EDGE=0, IRQ_EN=0, debounce counters=0
  - sync flops and stable state=all-ones (released)
- Register map, word offsets:
  - 0x00 LED_REG: RW, bits [NUM_LED-1:0]; upper bits read 0.
  - 0x04 BTN_STATE: RO, debounced level with 1 = pressed (inverted from pins).
  - 0x08 BTN_EDGE: sticky press events, write-1-to-clear.
  - 0x0C IRQ_EN: RW per-button enable.
  - Unmapped offsets read 0 and ignore writes.
- Write timing: takes effect on the clock edge where bus_we=1. led = LED_REG, registered, so an LED update is visible 1 cycle after the write.
- Read timing: registered, 1-cycle latency. bus_rvalid pulses the cycle after bus_re; bus_rdata holds its value until the next read.
- bus_we and bus_re asserted together: the write is performed, and the read returns the pre-write value.
- Per-button input path:
  - 2-flop synchroniser on btn_n.
  - When the synced value differs from the stable value, the counter increments.
  - When the synced value equals the stable value, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable takes the synced value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
  - Press-to-BTN_STATE latency = 2 + DEBOUNCE_CYCLES cycles.
- Edge capture: a stable 1->0 transition (press) sets EDGE[i]; release sets nothing.
- W1C collision: if a W1C to bit i and a new press on i occur in the same cycle, the set wins and the bit stays 1.
- Interrupt: irq = |(EDGE & IRQ_EN), registered, 1 cycle after the cause. Clearing either EDGE or IRQ_EN deasserts irq the next cycle.
- Counter width is $clog2(DEBOUNCE_CYCLES); the counter never wraps.
- Reset mid-debounce discards the in-progress count; buttons held through reset are seen as a fresh press after release of KEY + 2 + DEBOUNCE_CYCLES.

Optional Feature:
BOARD_GPIO_BLINK_EN
- Defined:
  - Adds 0x10 BLINK_MASK (RW, NUM_LED bits, reset 0).
  - A free-running counter toggles blink_phase every BLINK_DIV cycles; blink_phase resets to 0.
  - led = LED_REG ^ (BLINK_MASK & {NUM_LED{blink_phase}}), registered.
- Undefined:
  - 0x10 is unmapped (reads 0, writes ignored).
  - No blink counter logic is generated.
  - led = LED_REG.

Test Plan:
1. KEY=0 for 10 cycles with btn_n=0 and bus_we pulsing -> led=0, irq=0, bus_rvalid=0, and every register reads 0 after release.
2. Write 0x0003_FFFF to 0x00 -> led=18'h3FFFF one cycle later. Read 0x00 -> bus_rvalid next cycle, rdata=0x0003FFFF. Read 0x14 -> rdata=0.
3. With DEBOUNCE_CYCLES=8:
   - btn_n[1] low for 5 cycles, then high -> BTN_STATE=0, EDGE=0.
   - btn_n[1] held low -> BTN_STATE=0x2 exactly 10 cycles after the pin change, EDGE=0x2.
4. IRQ_EN=0x2 and EDGE[1]=1 -> irq=1. Write 0x2 to 0x08 -> irq=0 the following cycle.
5. W1C of 0x1 to 0x08 in the same cycle button 0's stable state goes pressed -> EDGE[0] remains 1 and irq stays asserted if enabled.
6. With BOARD_GPIO_BLINK_EN, BLINK_DIV=4, LED_REG=0x0F, BLINK_MASK=0x03 -> led alternates 0x0F/0x0C every 4 cycles. Without the macro, led is a steady 0x0F.
